// File: rtl/pipelined_cia_adder_if.sv
// ---------------------------------------------------------------------------
// pipelined_cia_adder_if
//   Handshake bundle for the pipelined carry-increment adder.
//   Operand side : in_valid/in_ready, in1, in2, cin, sub
//   Result side  : out_valid/out_ready, sum, cout, ovf
//   master = producer of operands / consumer of results (the environment)
//   slave  = the adder itself
// ---------------------------------------------------------------------------
interface pipelined_cia_adder_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, in1, in2, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, in1, in2, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_cia_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cia_adder
//   Two-stage carry-increment adder/subtractor with valid/ready flow control.
//   S1 ripples every BLK-bit block independently (block 0 with the real
//   carry-in, the rest with 0). S2 walks the block carries and increments
//   each partial sum, then registers sum/cout/ovf.
//
//   Parameters : N   operand width (multiple of BLK, >= 2*BLK)
//                BLK carry-increment block width (>= 2)
//   Ports      : clk   rising-edge clock
//                rst_n asynchronous active-low reset
//                bus   pipelined_cia_adder_if.slave (operand + result handshakes)
// ---------------------------------------------------------------------------

// Per-block increment: adds a single carry to a partial sum with a
// half-adder chain and reports the carry that falls out of the top.
module pipelined_cia_adder_inc #(
    parameter int BLK = 8
) (
    input  logic [BLK-1:0] psum_i,
    input  logic           c_i,
    output logic [BLK-1:0] sum_o,
    output logic           ic_o
);
    always_comb begin : ha_chain
        logic c;
        c     = c_i;
        sum_o = '0;
        for (int i = 0; i < BLK; i++) begin
            sum_o[i] = psum_i[i] ^ c;
            c        = psum_i[i] & c;
        end
        ic_o = c;
    end
endmodule

module pipelined_cia_adder #(
    parameter int N   = 32,
    parameter int BLK = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_cia_adder_if.slave  bus
);
    localparam int NB = N / BLK;

    // -----------------------------------------------------------------------
    // Operand conditioning: subtraction is in1 + ~in2 + 1
    // -----------------------------------------------------------------------
    logic [N-1:0] beff;
    logic         cin_eff;

    assign beff    = bus.sub ? ~bus.in2 : bus.in2;
    assign cin_eff = bus.sub | bus.cin;

    // -----------------------------------------------------------------------
    // S1 combinational: independent ripple per block
    // -----------------------------------------------------------------------
    logic [NB-1:0][BLK-1:0] rs_d;
    logic [NB-1:0]          rc_d;

    always_comb begin : ripple
        logic c;
        logic a_b;
        logic b_b;
        rs_d = '0;
        rc_d = '0;
        c    = 1'b0;
        a_b  = 1'b0;
        b_b  = 1'b0;
        for (int k = 0; k < NB; k++) begin
            c = (k == 0) ? cin_eff : 1'b0;
            for (int i = 0; i < BLK; i++) begin
                a_b        = bus.in1[k*BLK + i];
                b_b        = beff[k*BLK + i];
                rs_d[k][i] = a_b ^ b_b ^ c;
                c          = (a_b & b_b) | (c & (a_b ^ b_b));
            end
            rc_d[k] = c;
        end
    end

    // -----------------------------------------------------------------------
    // Flow control
    //   s2_adv : output register can take whatever S1 holds this cycle
    //   accept : operands transfer into S1
    // -----------------------------------------------------------------------
    logic s1_vld_q, s1_vld_d;
    logic out_vld_q, out_vld_d;
    logic s2_adv;
    logic accept;

    assign s2_adv       = ~out_vld_q | bus.out_ready;
    assign bus.in_ready = rst_n & (~s1_vld_q | s2_adv);
    assign accept       = bus.in_valid & bus.in_ready;

    assign s1_vld_d  = accept | (s1_vld_q & ~s2_adv);
    assign out_vld_d = s2_adv ? s1_vld_q : out_vld_q;

    // -----------------------------------------------------------------------
    // S1 registers
    // -----------------------------------------------------------------------
    logic [NB-1:0][BLK-1:0] s1_psum_q;
    logic [NB-1:0]          s1_rc_q;
    logic                   s1_amsb_q;
    logic                   s1_bmsb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_psum_q <= '0;
            s1_rc_q   <= '0;
            s1_amsb_q <= 1'b0;
            s1_bmsb_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            if (accept) begin
                s1_psum_q <= rs_d;
                s1_rc_q   <= rc_d;
                s1_amsb_q <= bus.in1[N-1];
                s1_bmsb_q <= beff[N-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // S2 combinational: carry increment
    //   blk_cin[k] is the carry entering block k. Block 0 already absorbed
    //   the real carry-in during S1, so it sees 0 here; every later block
    //   sees rc|ic of the block below it.
    // -----------------------------------------------------------------------
    logic [NB:0]            blk_cin;
    logic [NB-1:0]          blk_ic;
    logic [NB-1:0][BLK-1:0] s2_sum;
    logic [N-1:0]           sum_d;
    logic                   cout_d;
    logic                   ovf_d;

    assign blk_cin[0] = 1'b0;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        pipelined_cia_adder_inc #(.BLK(BLK)) u_inc (
            .psum_i (s1_psum_q[k]),
            .c_i    (blk_cin[k]),
            .sum_o  (s2_sum[k]),
            .ic_o   (blk_ic[k])
        );
        assign blk_cin[k+1] = s1_rc_q[k] | blk_ic[k];
    end

    assign sum_d  = s2_sum;
    assign cout_d = blk_cin[NB];
    assign ovf_d  = (s1_amsb_q == s1_bmsb_q) & (sum_d[N-1] != s1_amsb_q);

    // -----------------------------------------------------------------------
    // Output register: data only moves when a valid S1 entry advances, so a
    // stalled result stays put.
    // -----------------------------------------------------------------------
    logic [N-1:0] sum_q;
    logic         cout_q;
    logic         ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            out_vld_q <= out_vld_d;
            if (s2_adv && s1_vld_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_cia_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_cia_adder
//   Scoreboard bench: accepted operands push a reference result (plain
//   wide-integer arithmetic) into a per-instance queue; monitors pop and
//   compare on every output transfer. Three instances: 32/8 (directed +
//   random streaming), 16/4 and 64/16 (random sweep).
// ---------------------------------------------------------------------------
module tb_pipelined_cia_adder;
    typedef struct {
        logic [63:0] sum;
        logic        co;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;
    int   checks   = 0;
    int   failures = 0;
    bit   rand_rdy = 1'b0;
    exp_t q32[$];
    exp_t q16[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    pipelined_cia_adder_if #(.N(32)) if32 ();
    pipelined_cia_adder_if #(.N(16)) if16 ();
    pipelined_cia_adder_if #(.N(64)) if64 ();

    pipelined_cia_adder #(.N(32), .BLK(8))  dut32 (.clk(clk), .rst_n(rst_n),  .bus(if32.slave));
    pipelined_cia_adder #(.N(16), .BLK(4))  dut16 (.clk(clk), .rst_n(rst2_n), .bus(if16.slave));
    pipelined_cia_adder #(.N(64), .BLK(16)) dut64 (.clk(clk), .rst_n(rst2_n), .bus(if64.slave));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference: (a + Beff + cin_eff) mod 2^n, carry is bit n of the wide sum.
    function automatic exp_t model(int n, logic [63:0] a, logic [63:0] b, logic c, logic s);
        logic [63:0] m;
        logic [63:0] be;
        logic [64:0] t;
        exp_t        e;
        m     = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
        be    = s ? (~b & m) : (b & m);
        t     = {1'b0, a & m} + {1'b0, be} + {64'd0, (s ? 1'b1 : c)};
        e.sum = t[63:0] & m;
        e.co  = t[n];
        e.ov  = (a[n-1] == be[n-1]) && (e.sum[n-1] != a[n-1]);
        return e;
    endfunction

    function automatic logic [63:0] pick(int n, int sel);
        logic [63:0] m;
        m = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
        case (sel)
            0:       return 64'd0;
            1:       return m;
            2:       return 64'd1 << (n - 1);
            3:       return m >> 1;
            4:       return 64'd1;
            default: return {$urandom, $urandom} & m;
        endcase
    endfunction

    // ---------------- monitors / scoreboards ----------------
    logic        p_stall = 1'b0;
    logic [33:0] p_out   = '0;

    always @(negedge clk) begin : mon32
        exp_t e;
        if (!rst_n) begin
            p_stall = 1'b0;
        end else begin
            if (if32.in_valid && if32.in_ready)
                q32.push_back(model(32, 64'(if32.in1), 64'(if32.in2), if32.cin, if32.sub));
            if (p_stall)
                chk("hold32", 64'({if32.out_valid, if32.sum, if32.cout, if32.ovf}), 64'({1'b1, p_out}));
            if (if32.out_valid && if32.out_ready) begin
                if (q32.size() == 0) begin
                    chk("extra32_valid", 64'(if32.out_valid), 64'd0);
                end else begin
                    e = q32.pop_front();
                    chk("sum32",  64'(if32.sum),  e.sum);
                    chk("cout32", 64'(if32.cout), 64'(e.co));
                    chk("ovf32",  64'(if32.ovf),  64'(e.ov));
                end
            end
            p_stall = if32.out_valid && !if32.out_ready;
            p_out   = {if32.sum, if32.cout, if32.ovf};
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (rst2_n) begin
            if (if16.in_valid && if16.in_ready)
                q16.push_back(model(16, 64'(if16.in1), 64'(if16.in2), if16.cin, if16.sub));
            if (if16.out_valid && if16.out_ready) begin
                if (q16.size() == 0) begin
                    chk("extra16_valid", 64'(if16.out_valid), 64'd0);
                end else begin
                    e = q16.pop_front();
                    chk("sum16",  64'(if16.sum),  e.sum);
                    chk("cout16", 64'(if16.cout), 64'(e.co));
                    chk("ovf16",  64'(if16.ovf),  64'(e.ov));
                end
            end
        end
    end

    always @(negedge clk) begin : mon64
        exp_t e;
        if (rst2_n) begin
            if (if64.in_valid && if64.in_ready)
                q64.push_back(model(64, if64.in1, if64.in2, if64.cin, if64.sub));
            if (if64.out_valid && if64.out_ready) begin
                if (q64.size() == 0) begin
                    chk("extra64_valid", 64'(if64.out_valid), 64'd0);
                end else begin
                    e = q64.pop_front();
                    chk("sum64",  if64.sum,           e.sum);
                    chk("cout64", 64'(if64.cout),     64'(e.co));
                    chk("ovf64",  64'(if64.ovf),      64'(e.ov));
                end
            end
        end
    end

    // Random backpressure for the streaming phase.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            if32.out_ready = ($urandom % 3) != 0;
        end
    end

    // ---------------- drivers (called at posedge+small delay) ----------------
    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
        int n;
        if32.in1 = a; if32.in2 = b; if32.cin = c; if32.sub = s;
        if32.in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if32.in_ready && n < 200);
        if (!if32.in_ready) chk("accept_timeout", 64'(if32.in_ready), 64'd1);
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
    endtask

    // Empty pipeline, out_ready=1: result must show up exactly two edges later.
    task automatic lat32(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                         input logic [31:0] esum, input logic eco, input logic eov);
        if32.in1 = a; if32.in2 = b; if32.cin = c; if32.sub = s;
        if32.in_valid = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", 64'(if32.in_ready), 64'd1);
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_edge1_out_valid", 64'(if32.out_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_edge2_out_valid", 64'(if32.out_valid), 64'd1);
        chk("dir_sum",  64'(if32.sum),  64'(esum));
        chk("dir_cout", 64'(if32.cout), 64'(eco));
        chk("dir_ovf",  64'(if32.ovf),  64'(eov));
        @(posedge clk); #1;
    endtask

    task automatic main_seq();
        if32.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(if32.out_valid), 64'd0);
        chk("rst_in_ready",  64'(if32.in_ready),  64'd0);
        chk("rst_sum",       64'(if32.sum),       64'd0);
        chk("rst_cout_ovf",  64'({if32.cout, if32.ovf}), 64'd0);
        rst_n = 1'b1;

        // first cycle after release accepts
        lat32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        lat32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        lat32(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

        // backpressure: two go in, third waits
        if32.out_ready = 1'b0;
        send32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        send32(32'hA000_0000, 32'h2000_0000, 1'b0, 1'b1);
        if32.in1 = 32'hDEAD_BEEF; if32.in2 = 32'h0000_0001; if32.cin = 1'b1; if32.sub = 1'b0;
        if32.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready",  64'(if32.in_ready),  64'd0);
            chk("bp_out_valid", 64'(if32.out_valid), 64'd1);
            chk("bp_head_sum",  64'(if32.sum),       64'h2345_6789);
        end
        @(posedge clk); #1;
        if32.out_ready = 1'b1;
        send32(32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // reset with two transactions in flight
        if32.out_ready = 1'b0;
        send32(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0);
        send32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(if32.out_valid), 64'd0);
        chk("mrst_sum",       64'(if32.sum),       64'd0);
        chk("mrst_in_ready",  64'(if32.in_ready),  64'd0);
        q32.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        if32.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("mrst_no_stale", 64'(if32.out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // streaming with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 100; i++)
            send32(32'(pick(32, $urandom_range(0, 7))), 32'(pick(32, $urandom_range(0, 7))),
                   1'($urandom), 1'($urandom));
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        if32.out_ready = 1'b1;
    endtask

    task automatic sweep();
        repeat (2) @(posedge clk);
        #1;
        rst2_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if16.in1 = 16'(pick(16, $urandom_range(0, 7)));
            if16.in2 = 16'(pick(16, $urandom_range(0, 7)));
            if16.cin = 1'($urandom);
            if16.sub = 1'($urandom);
            if16.in_valid  = ($urandom % 4) != 0;
            if16.out_ready = ($urandom % 4) != 0;
            if64.in1 = pick(64, $urandom_range(0, 7));
            if64.in2 = pick(64, $urandom_range(0, 7));
            if64.cin = 1'($urandom);
            if64.sub = 1'($urandom);
            if64.in_valid  = ($urandom % 4) != 0;
            if64.out_ready = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end
        if16.in_valid = 1'b0; if16.out_ready = 1'b1;
        if64.in_valid = 1'b0; if64.out_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        if32.in_valid = 1'b0; if32.in1 = '0; if32.in2 = '0; if32.cin = 1'b0; if32.sub = 1'b0; if32.out_ready = 1'b1;
        if16.in_valid = 1'b0; if16.in1 = '0; if16.in2 = '0; if16.cin = 1'b0; if16.sub = 1'b0; if16.out_ready = 1'b1;
        if64.in_valid = 1'b0; if64.in1 = '0; if64.in2 = '0; if64.cin = 1'b0; if64.sub = 1'b0; if64.out_ready = 1'b1;
        fork
            main_seq();
            sweep();
        join
        for (int i = 0; i < 200 && (q32.size() + q16.size() + q64.size()) != 0; i++)
            @(negedge clk);
        @(negedge clk);
        chk("q32_left", 64'(q32.size()), 64'd0);
        chk("q16_left", 64'(q16.size()), 64'd0);
        chk("q64_left", 64'(q64.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipelined_cia_adder.md
PIPELINED_CIA_ADDER -- requirements
Module: pipelined_cia_adder

Interface
REQ-001 SHALL have parameter N, default 32: operand/sum width; a multiple of BLK and at least 2*BLK.
REQ-002 SHALL have parameter BLK, default 8: carry-increment block width; at least 2.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand transfer request.
REQ-006 SHALL have port in_ready  output  1  block can accept operands this cycle.
REQ-007 SHALL have ports in1, in2  input  N  operands.
REQ-008 SHALL have port cin  input  1  carry-in; used in add mode only.
REQ-009 SHALL have port sub  input  1  0 = in1+in2+cin, 1 = in1-in2 (in1 + ~in2 + 1).
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  N  result.
REQ-013 SHALL have port cout  output  1  unsigned carry-out; in sub mode 1 = no borrow.
REQ-014 SHALL have port ovf  output  1  two's-complement overflow.

Function
REQ-015 SHALL accept a transaction on a cycle with in_valid=1 and in_ready=1; on any other cycle it SHALL ignore the inputs.
REQ-016 SHALL form the effective B operand as sub ? ~in2 : in2 and the effective carry-in as sub ? 1 : cin.
REQ-017 SHALL be a 2-stage pipeline. Stage 1 (S1) registers, per operand:
- block 0: ripple sum and carry using the effective carry-in;
- each block k = 1..N/BLK-1: ripple sum and carry with carry-in 0;
- A MSB, effective-B MSB, and a valid bit.
REQ-018 Stage 2 (S2) SHALL apply carry increment.
- The incoming carry of block k is c(k) = rc(k-1) | ic(k-1), where rc is the ripple carry and ic is the increment carry.
- c(1) = rc(0).
- Each block adds c(k) to its partial sum with a half-adder chain.
- S2 registers the result into sum, cout and ovf.
REQ-019 SHALL compute cout as the carry out of the top block, given by rc | ic of that block.
REQ-020 SHALL compute ovf as (A_msb == Beff_msb) and (sum[N-1] != A_msb).
REQ-021 SHALL make sum equal to (in1 + Beff + cin_eff) mod 2^N for every N/BLK combination.
REQ-022 SHALL present a result with out_valid=1 exactly 2 clock edges after acceptance when out_ready stays 1, with no combinational input-to-output path.
REQ-023 SHALL sustain throughput of one transaction per cycle with in_valid=1 and out_ready=1.
REQ-024 SHALL advance S1 into the output register when the output is empty or out_ready=1.
REQ-025 SHALL drive in_ready = rst_n and (S1 empty or S1 advancing); in_ready is combinational from out_ready.
REQ-026 SHALL hold sum, cout and ovf stable while out_valid=1 and out_ready=0.
REQ-027 SHALL hold at most 2 transactions in flight: one in S1 and one in the output register.
REQ-028 SHALL deliver results in acceptance order, with no loss or duplication under any in_valid/out_ready pattern.
REQ-029 SHALL support a simultaneous accept and output retire in the same cycle without a bubble.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force S1 valid, out_valid, sum, cout and ovf to 0, and in_ready to 0.
REQ-031 SHALL discard all in-flight transactions when rst_n is asserted mid-operation.
REQ-032 SHALL accept a transaction in the first cycle after rst_n deasserts.

Verification
REQ-033 N=32, BLK=8: in1=FFFFFFFF, in2=00000001, cin=0, sub=0, out_ready=1 -> after 2 cycles sum=00000000, cout=1, ovf=0 (carry increments across all blocks).
REQ-034 in1=7FFFFFFF, in2=00000001, sub=0 -> sum=80000000, cout=0, ovf=1; in1=00000005, in2=00000007, sub=1 -> sum=FFFFFFFE, cout=0, ovf=0.
REQ-035 Backpressure: out_ready=0, in_valid=1 with 3 distinct operand sets -> 2 accepted, then in_ready=0 and output stable; raise out_ready -> results appear in order, third accepted.
REQ-036 Streaming: 100 back-to-back random operands with out_ready toggled randomly -> every result matches the golden model, in order, and out_valid is never high with stale data.
REQ-037 Reset mid-operation: assert rst_n=0 with 2 transactions in flight -> out_valid=0 and sum=0 immediately; after release, no stale result ever appears.
REQ-038 Parameter sweep: N=16/BLK=4 and N=64/BLK=16 with 1000 random operands plus cin/sub corners -> sum, cout and ovf match the golden model.
